// File: rtl/pic_pkg.sv
// Shared command opcodes and handshake state encoding for the rotating priority resolver.
package pic_pkg;

    localparam logic [2:0] NOP          = 3'd0;
    localparam logic [2:0] EOI_NS       = 3'd1;
    localparam logic [2:0] EOI_SP       = 3'd2;
    localparam logic [2:0] ROT_NS       = 3'd3;
    localparam logic [2:0] ROT_SP       = 3'd4;
    localparam logic [2:0] SET_PRIO     = 3'd5;
    localparam logic [2:0] AEOI_ROT_ON  = 3'd6;
    localparam logic [2:0] AEOI_ROT_OFF = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/rot_priority_pick.sv
// Finds the highest-priority set bit of vec when (lowest+1) mod N is top priority.
module rot_priority_pick #(
    parameter  int NUM_IRQ = 8,
    localparam int IDX_W   = $clog2(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] vec,
    input  logic [IDX_W-1:0]   lowest,
    output logic               found,
    output logic [IDX_W-1:0]   level
);

    logic [IDX_W-1:0] start;
    logic [IDX_W-1:0] k;

    assign start = lowest + IDX_W'(1);

    // Scan from the lowest rank down so the last hit is the first set bit of the rotated vector.
    always_comb begin
        k = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (vec[start + IDX_W'(i)]) begin
                k = IDX_W'(i);
            end
        end
    end

    assign found = |vec;
    assign level = start + k;

endmodule

// File: rtl/rotating_priority_resolver.sv
// Rotating-priority ISR/pointer bookkeeping and CPU interrupt handshake for NUM_IRQ request lines.
module rotating_priority_resolver
    import pic_pkg::*;
#(
    parameter  int NUM_IRQ = 8,
    localparam int IDX_W   = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               aeoi_mode,
    input  logic               cmd_valid,
    input  logic [2:0]         cmd_op,
    input  logic [IDX_W-1:0]   cmd_level,
    input  logic               int_ack,
    output logic               int_out,
    output logic               ack_valid,
    output logic [IDX_W-1:0]   ack_level,
    output logic               ack_spurious,
    output logic [NUM_IRQ-1:0] irq_clear,
    output logic [NUM_IRQ-1:0] isr,
    output logic [IDX_W-1:0]   lowest_prio
);

    state_e             state_q, state_d;
    logic [NUM_IRQ-1:0] isr_q, isr_d;
    logic [NUM_IRQ-1:0] irq_clear_q, irq_clear_d;
    logic [IDX_W-1:0]   low_q, low_d;
    logic [IDX_W-1:0]   ack_level_q, ack_level_d;
    logic               rot_aeoi_q, rot_aeoi_d;
    logic               ack_valid_q, ack_valid_d;
    logic               ack_spurious_q, ack_spurious_d;

    logic [NUM_IRQ-1:0] pend;
    logic               req_found, isr_found;
    logic [IDX_W-1:0]   req_top, isr_top;
    logic [IDX_W-1:0]   start, rank_req, rank_isr;
    logic               eligible;
    logic               ack_fire;
    logic [NUM_IRQ-1:0] set_vec, clr_vec;

    assign pend = irq_req & ~irq_mask;

    rot_priority_pick #(.NUM_IRQ(NUM_IRQ)) u_pick_req (
        .vec    (pend),
        .lowest (low_q),
        .found  (req_found),
        .level  (req_top)
    );

    rot_priority_pick #(.NUM_IRQ(NUM_IRQ)) u_pick_isr (
        .vec    (isr_q),
        .lowest (low_q),
        .found  (isr_found),
        .level  (isr_top)
    );

    // Rank 0 is the top priority; comparing ranks avoids wrap-around cases.
    assign start    = low_q + IDX_W'(1);
    assign rank_req = req_top - start;
    assign rank_isr = isr_top - start;
    assign eligible = req_found && (!isr_found || (rank_req < rank_isr));
    assign ack_fire = (state_q == REQ) && int_ack;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (eligible) state_d = REQ;
            REQ:     if (int_ack)  state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        set_vec        = '0;
        clr_vec        = '0;
        low_d          = low_q;
        rot_aeoi_d     = rot_aeoi_q;
        ack_valid_d    = ack_fire;
        ack_spurious_d = ack_fire && !eligible;
        ack_level_d    = ack_level_q;
        irq_clear_d    = '0;

        if (ack_fire) begin
            if (eligible) begin
                ack_level_d          = req_top;
                irq_clear_d[req_top] = 1'b1;
                if (!aeoi_mode) begin
                    set_vec[req_top] = 1'b1;
                end else if (rot_aeoi_q) begin
                    low_d = req_top;
                end
            end else begin
                ack_level_d = IDX_W'(NUM_IRQ - 1);
            end
        end

        // Commands act on pre-cycle isr/L; their write to L overrides an AEOI rotation.
        if (cmd_valid) begin
            case (cmd_op)
                EOI_NS: begin
                    if (isr_found) clr_vec[isr_top] = 1'b1;
                end
                EOI_SP: clr_vec[cmd_level] = 1'b1;
                ROT_NS: begin
                    if (isr_found) begin
                        clr_vec[isr_top] = 1'b1;
                        low_d            = isr_top;
                    end
                end
                ROT_SP: begin
                    clr_vec[cmd_level] = 1'b1;
                    low_d              = cmd_level;
                end
                SET_PRIO:     low_d      = cmd_level;
                AEOI_ROT_ON:  rot_aeoi_d = 1'b1;
                AEOI_ROT_OFF: rot_aeoi_d = 1'b0;
                default: ;
            endcase
        end

        // An ack setting a bit beats a same-cycle clear of that bit.
        isr_d = (isr_q & ~clr_vec) | set_vec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            isr_q          <= '0;
            low_q          <= IDX_W'(NUM_IRQ - 1);
            rot_aeoi_q     <= 1'b0;
            ack_valid_q    <= 1'b0;
            ack_spurious_q <= 1'b0;
            ack_level_q    <= '0;
            irq_clear_q    <= '0;
        end else begin
            state_q        <= state_d;
            isr_q          <= isr_d;
            low_q          <= low_d;
            rot_aeoi_q     <= rot_aeoi_d;
            ack_valid_q    <= ack_valid_d;
            ack_spurious_q <= ack_spurious_d;
            ack_level_q    <= ack_level_d;
            irq_clear_q    <= irq_clear_d;
        end
    end

    assign int_out      = (state_q == REQ);
    assign ack_valid    = ack_valid_q;
    assign ack_level    = ack_level_q;
    assign ack_spurious = ack_spurious_q;
    assign irq_clear    = irq_clear_q;
    assign isr          = isr_q;
    assign lowest_prio  = low_q;

endmodule

// File: tb/tb_rotating_priority_resolver.sv
// Directed trace bench for rotating_priority_resolver with NUM_IRQ=8.
module tb_rotating_priority_resolver;
    import pic_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] irq_req;
    logic [7:0] irq_mask;
    logic       aeoi_mode;
    logic       cmd_valid;
    logic [2:0] cmd_op;
    logic [2:0] cmd_level;
    logic       int_ack;
    logic       int_out;
    logic       ack_valid;
    logic [2:0] ack_level;
    logic       ack_spurious;
    logic [7:0] irq_clear;
    logic [7:0] isr;
    logic [2:0] lowest_prio;

    rotating_priority_resolver #(.NUM_IRQ(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_req      (irq_req),
        .irq_mask     (irq_mask),
        .aeoi_mode    (aeoi_mode),
        .cmd_valid    (cmd_valid),
        .cmd_op       (cmd_op),
        .cmd_level    (cmd_level),
        .int_ack      (int_ack),
        .int_out      (int_out),
        .ack_valid    (ack_valid),
        .ack_level    (ack_level),
        .ack_spurious (ack_spurious),
        .irq_clear    (irq_clear),
        .isr          (isr),
        .lowest_prio  (lowest_prio)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int req, msk, aeoi, cv, op, lvl, ack;
        int io, av, al, sp, clr, isr, lp;
    } vec_t;

    vec_t tbl[$];
    int   n_chk;
    int   n_fail;

    task automatic add(input int req, msk, aeoi, cv, op, lvl, ack,
                       input int io, av, al, sp, clr, isr_e, lp);
        vec_t v;
        v.req = req; v.msk = msk; v.aeoi = aeoi; v.cv = cv; v.op = op; v.lvl = lvl; v.ack = ack;
        v.io = io; v.av = av; v.al = al; v.sp = sp; v.clr = clr; v.isr = isr_e; v.lp = lp;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int req, aeoi, cv, op, lvl, ack);
        irq_req   = 8'(req);
        irq_mask  = 8'h00;
        aeoi_mode = 1'(aeoi);
        cmd_valid = 1'(cv);
        cmd_op    = 3'(op);
        cmd_level = 3'(lvl);
        int_ack   = 1'(ack);
    endtask

    task automatic chk_all(input string tag, input int io, av, al, sp, clr, isr_e, lp);
        chk({tag, ".int_out"},   32'(int_out),      32'(io));
        chk({tag, ".ack_valid"}, 32'(ack_valid),    32'(av));
        chk({tag, ".ack_level"}, 32'(ack_level),    32'(al));
        chk({tag, ".spurious"},  32'(ack_spurious), 32'(sp));
        chk({tag, ".irq_clear"}, 32'(irq_clear),    32'(clr));
        chk({tag, ".isr"},       32'(isr),          32'(isr_e));
        chk({tag, ".lowest"},    32'(lowest_prio),  32'(lp));
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;

        //   req   msk  aeo cv op            lvl ack   io av al sp clr   isr   lp
        add(8'h28, 0,   0, 0, 0,            0,  0,    1, 0, 0, 0, 8'h00, 8'h00, 7);
        add(8'h28, 0,   0, 0, 0,            0,  1,    0, 1, 3, 0, 8'h08, 8'h08, 7);
        add(8'h20, 0,   0, 0, 0,            0,  0,    0, 0, 3, 0, 8'h00, 8'h08, 7);
        add(8'h22, 2,   0, 0, 0,            0,  0,    0, 0, 3, 0, 8'h00, 8'h08, 7);
        add(8'h22, 0,   0, 0, 0,            0,  0,    1, 0, 3, 0, 8'h00, 8'h08, 7);
        add(8'h22, 0,   0, 0, 0,            0,  1,    0, 1, 1, 0, 8'h02, 8'h0A, 7);
        add(8'h20, 0,   0, 0, 0,            0,  0,    0, 0, 1, 0, 8'h00, 8'h0A, 7);
        add(8'h20, 0,   0, 1, EOI_NS,       0,  0,    0, 0, 1, 0, 8'h00, 8'h08, 7);
        add(8'h00, 0,   0, 1, EOI_SP,       3,  0,    0, 0, 1, 0, 8'h00, 8'h00, 7);
        add(8'h00, 0,   0, 1, SET_PRIO,     4,  0,    0, 0, 1, 0, 8'h00, 8'h00, 4);
        add(8'h21, 0,   0, 0, 0,            0,  0,    1, 0, 1, 0, 8'h00, 8'h00, 4);
        add(8'h21, 0,   0, 0, 0,            0,  1,    0, 1, 5, 0, 8'h20, 8'h20, 4);
        add(8'h01, 0,   0, 0, 0,            0,  0,    0, 0, 5, 0, 8'h00, 8'h20, 4);
        add(8'h00, 0,   0, 1, ROT_NS,       0,  0,    0, 0, 5, 0, 8'h00, 8'h00, 5);
        add(8'h00, 0,   1, 1, AEOI_ROT_ON,  0,  0,    0, 0, 5, 0, 8'h00, 8'h00, 5);
        add(8'h01, 0,   1, 0, 0,            0,  0,    1, 0, 5, 0, 8'h00, 8'h00, 5);
        add(8'h01, 0,   1, 0, 0,            0,  1,    0, 1, 0, 0, 8'h01, 8'h00, 0);
        add(8'h00, 0,   1, 0, 0,            0,  0,    0, 0, 0, 0, 8'h00, 8'h00, 0);
        add(8'h00, 0,   1, 1, AEOI_ROT_OFF, 0,  0,    0, 0, 0, 0, 8'h00, 8'h00, 0);
        add(8'h04, 0,   1, 0, 0,            0,  0,    1, 0, 0, 0, 8'h00, 8'h00, 0);
        add(8'h04, 0,   1, 0, 0,            0,  1,    0, 1, 2, 0, 8'h04, 8'h00, 0);
        add(8'h00, 0,   0, 0, 0,            0,  0,    0, 0, 2, 0, 8'h00, 8'h00, 0);
        add(8'h10, 0,   0, 0, 0,            0,  0,    1, 0, 2, 0, 8'h00, 8'h00, 0);
        add(8'h00, 0,   0, 0, 0,            0,  0,    1, 0, 2, 0, 8'h00, 8'h00, 0);
        add(8'h00, 0,   0, 0, 0,            0,  1,    0, 1, 7, 1, 8'h00, 8'h00, 0);
        add(8'h00, 0,   0, 0, 0,            0,  0,    0, 0, 7, 0, 8'h00, 8'h00, 0);
        add(8'h00, 0,   0, 0, 0,            0,  1,    0, 0, 7, 0, 8'h00, 8'h00, 0);
        add(8'h00, 0,   0, 1, ROT_NS,       0,  0,    0, 0, 7, 0, 8'h00, 8'h00, 0);

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        step();
        step();
        chk_all("reset", 0, 0, 0, 0, 8'h00, 8'h00, 7);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].req, tbl[i].aeoi, tbl[i].cv, tbl[i].op, tbl[i].lvl, tbl[i].ack);
            irq_mask = 8'(tbl[i].msk);
            step();
            chk_all($sformatf("r%0d", i), tbl[i].io, tbl[i].av, tbl[i].al, tbl[i].sp,
                    tbl[i].clr, tbl[i].isr, tbl[i].lp);
        end

        // Same-cycle ack of level 2 and EOI_SP level 2: the ack's set survives.
        drive(8'h04, 0, 0, 0, 0, 0);
        step();
        chk("same.req", 32'(int_out), 32'd1);
        drive(8'h04, 0, 1, EOI_SP, 2, 1);
        step();
        chk_all("same.ack", 0, 1, 2, 0, 8'h04, 8'h04, 0);
        drive(8'h00, 0, 0, 0, 0, 0);
        step();
        drive(8'h00, 0, 1, ROT_SP, 2, 0);
        step();
        chk_all("rotsp", 0, 0, 2, 0, 8'h00, 8'h00, 2);

        // Reach REQ with a nonzero ISR, then reset asynchronously mid-request.
        drive(8'h01, 0, 0, 0, 0, 0);
        step();
        chk("midreq.req0", 32'(int_out), 32'd1);
        drive(8'h01, 0, 0, 0, 0, 1);
        step();
        chk_all("midreq.ack0", 0, 1, 0, 0, 8'h01, 8'h01, 2);
        drive(8'h08, 0, 0, 0, 0, 0);
        step();
        chk("midreq.hold", 32'(int_out), 32'd0);
        step();
        chk("midreq.req3", 32'(int_out), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 8'h00, 8'h00, 7);
        drive(8'h00, 0, 0, 0, 0, 0);
        step();
        rst_n = 1'b1;

        // A command write to L beats a same-cycle AEOI rotation.
        drive(8'h00, 1, 1, AEOI_ROT_ON, 0, 0);
        step();
        drive(8'h02, 1, 0, 0, 0, 0);
        step();
        chk("prio.req", 32'(int_out), 32'd1);
        drive(8'h02, 1, 1, SET_PRIO, 6, 1);
        step();
        chk_all("prio.ack", 0, 1, 1, 0, 8'h02, 8'h00, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rotating_priority_resolver.md
Name: rotating_priority_resolver

Overview:
Parametrised successor to the 8-bit priority rotator. Holds the lowest-priority pointer, the in-service register (ISR) and the interrupt handshake for N request lines. Resolves the highest-priority unmasked request under a rotating priority scheme. Sits between the IRR/IMR logic and the control/cascade logic of the PIC core.

Parameters:
NUM_IRQ, 8, number of request lines; power of 2, >= 2
IDX_W, $clog2(NUM_IRQ), width of a level index (derived; not overridden)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
irq_req  in  NUM_IRQ  latched request register (IRR), level per bit
irq_mask  in  NUM_IRQ  interrupt mask (1 = masked)
aeoi_mode  in  1  automatic EOI: ack does not set ISR
cmd_valid  in  1  single-cycle command strobe
cmd_op  in  3  command opcode (package constants)
cmd_level  in  IDX_W  level operand for specific commands
int_ack  in  1  single-cycle acknowledge from CPU side
int_out  out  1  interrupt request to CPU
ack_valid  out  1  one-cycle pulse: ack_level/ack_spurious valid
ack_level  out  IDX_W  acknowledged level
ack_spurious  out  1  ack had no eligible request
irq_clear  out  NUM_IRQ  one-hot pulse clearing the IRR bit of the acked level
isr  out  NUM_IRQ  in-service register
lowest_prio  out  IDX_W  current lowest-priority level L

Behaviour:
- Reset (async, rst_n=0): isr=0, L=NUM_IRQ-1 (level 0 highest), rot_aeoi=0, FSM=IDLE. int_out, ack_valid, ack_spurious, irq_clear=0; ack_level=0.
- Priority order: (L+1) mod N highest, descending cyclically to L lowest.
- pend = irq_req & ~irq_mask. req_top = highest-priority set bit of pend. isr_top = highest-priority set bit of isr. Both computed by rotating right by (L+1) mod N, finding first set bit k, and mapping back as (k+L+1) mod N. Index arithmetic is modulo N, IDX_W bits, natural wrap.
- eligible = pend!=0 and (isr==0 or req_top strictly higher priority than isr_top).
- FSM IDLE: eligible -> REQ; int_out registered, so it rises 1 cycle after eligible.
- FSM REQ: int_out=1. On int_ack -> HOLD. If eligible falls, int_out stays high until ack (no withdrawal).
- Ack capture (cycle of int_ack in REQ): if eligible, ack_level=req_top, irq_clear=onehot(req_top), and isr[req_top] is set unless aeoi_mode. If aeoi_mode and rot_aeoi, L=req_top. If not eligible: ack_level=NUM_IRQ-1, ack_spurious=1, no isr/irq_clear change.
- ack_valid, ack_level, ack_spurious and irq_clear are registered and appear the cycle after int_ack for exactly 1 cycle.
- FSM HOLD: int_out=0 for one cycle, then IDLE. int_ack in IDLE or HOLD is ignored (no outputs).
- Commands, applied on the cycle cmd_valid=1:
  - NOP: no effect.
  - EOI_NS: clear isr_top.
  - EOI_SP: clear cmd_level.
  - ROT_NS: clear isr_top and set L=isr_top.
  - ROT_SP: clear cmd_level and set L=cmd_level.
  - SET_PRIO: L=cmd_level.
  - AEOI_ROT_ON / AEOI_ROT_OFF: set / clear rot_aeoi.
  - Non-specific ops with isr==0 do nothing, including no rotation.
- Simultaneous ack and command in one cycle: the command evaluates on pre-cycle isr/L. The final ISR bit set by the ack wins over a clear of the same bit. A command write to L wins over an AEOI rotation.
- isr and lowest_prio outputs reflect the registers directly.

Decomposition:
- Package pic_pkg: cmd_op localparams NOP=0, EOI_NS=1, EOI_SP=2, ROT_NS=3, ROT_SP=4, SET_PRIO=5, AEOI_ROT_ON=6, AEOI_ROT_OFF=7; FSM state enum {IDLE, REQ, HOLD}.
- Sub-module rot_priority_pick (param NUM_IRQ): combinational; inputs vec and L; outputs found and level. Instanced twice, for pend and for isr.

Test Plan:
- Reset, irq_req=8'h28, mask=0 -> int_out=1 on the 2nd clk. Ack -> ack_level=3, irq_clear=8'h08, isr=8'h08.
- isr=8'h08, irq_req raises bit 5 -> int_out stays 0. irq_req bit 1 -> int_out=1; ack -> isr=8'h0A.
- SET_PRIO level 4, irq_req=8'h21 -> ack_level=5. Then ROT_NS -> isr=0, lowest_prio=5.
- aeoi_mode=1, AEOI_ROT_ON, irq_req=8'h01 -> ack_level=0, isr stays 0, lowest_prio=0.
- int_out high, request withdrawn before ack -> ack_level=7, ack_spurious=1, irq_clear=0.
- Same-cycle ack(level 2) and EOI_SP level 2 -> isr[2]=1. Reset mid-REQ -> all outputs at reset values immediately.
